// File: rtl/v33_bus_responder.sv
// v33_bus_responder: slave-side responder for a V33-style CPU bus.
// Decodes each bus cycle and runs it on a simple request/ack backend.
// Wait states are counted on ce_1 phases, and n_ready is driven back to the CPU.
`timescale 1ns/1ps

module v33_bus_responder (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        ce_1,
    input  logic        ce_2,
    input  logic        n_bcyst,
    input  logic        r_w,
    input  logic        m_io,
    input  logic        busst1,
    input  logic        busst0,
    input  logic        n_ube,
    input  logic [23:0] addr,
    input  logic [15:0] dout,
    output logic [15:0] din,
    output logic        n_ready,
    input  logic [3:0]  wait_states,
    input  logic [7:0]  int_vector,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [23:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        halt_ack,
    output logic        protocol_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_READY
    } state_t;

    typedef enum logic [2:0] {
        C_MEM_READ,
        C_MEM_WRITE,
        C_IO_READ,
        C_IO_WRITE,
        C_INT_ACK,
        C_HALT_ACK,
        C_INVALID
    } cyc_t;

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [23:0] addr_reg, addr_next;
    logic [15:0] wdata_reg, wdata_next;
    logic [1:0]  be_reg, be_next;
    logic        we_reg, we_next;
    logic        io_reg, io_next;
    logic        rd_reg, rd_next;       // cycle returns data to the CPU
    logic [15:0] resp_reg, resp_next;
    logic [15:0] din_reg, din_next;
    logic        n_ready_reg, n_ready_next;
    logic        halt_ack_reg, halt_ack_next;
    logic        perr_reg, perr_next;

    cyc_t        cyc_type;
    logic        is_access;
    logic        is_io;
    logic        is_write;
    logic        returns_data;
    logic        lane_err;
    logic        start;

    // Decode the CPU status pins into a cycle type.
    always_comb begin
        cyc_type = C_INVALID;
        case ({m_io, r_w, busst1, busst0})
            4'b1100, 4'b1101: cyc_type = C_MEM_READ;
            4'b1001:          cyc_type = C_MEM_WRITE;
            4'b0101:          cyc_type = C_IO_READ;
            4'b0001:          cyc_type = C_IO_WRITE;
            4'b0100:          cyc_type = C_INT_ACK;
            4'b0011:          cyc_type = C_HALT_ACK;
            default:          cyc_type = C_INVALID;
        endcase
    end

    assign is_access    = (cyc_type == C_MEM_READ) || (cyc_type == C_MEM_WRITE) ||
                          (cyc_type == C_IO_READ)  || (cyc_type == C_IO_WRITE);
    assign is_io        = (cyc_type == C_IO_READ)  || (cyc_type == C_IO_WRITE);
    assign is_write     = (cyc_type == C_MEM_WRITE) || (cyc_type == C_IO_WRITE);
    assign returns_data = (cyc_type == C_MEM_READ) || (cyc_type == C_IO_READ) ||
                          (cyc_type == C_INT_ACK);
    // An odd address with the upper lane disabled selects no byte at all.
    assign lane_err     = addr[0] & n_ube;
    assign start        = ce_2 & ~n_bcyst;

    // State and datapath registers; reset abandons any pending access.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
            addr_reg     <= 24'd0;
            wdata_reg    <= 16'd0;
            be_reg       <= 2'b00;
            we_reg       <= 1'b0;
            io_reg       <= 1'b0;
            rd_reg       <= 1'b0;
            resp_reg     <= 16'hffff;
            din_reg      <= 16'hffff;
            n_ready_reg  <= 1'b1;
            halt_ack_reg <= 1'b0;
            perr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            be_reg       <= be_next;
            we_reg       <= we_next;
            io_reg       <= io_next;
            rd_reg       <= rd_next;
            resp_reg     <= resp_next;
            din_reg      <= din_next;
            n_ready_reg  <= n_ready_next;
            halt_ack_reg <= halt_ack_next;
            perr_reg     <= perr_next;
        end
    end

    // Next-state logic: cycle latch, backend handshake, wait counting, completion.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        be_next       = be_reg;
        we_next       = we_reg;
        io_next       = io_reg;
        rd_next       = rd_reg;
        resp_next     = resp_reg;
        din_next      = din_reg;
        n_ready_next  = n_ready_reg;
        halt_ack_next = 1'b0;
        perr_next     = perr_reg;

        // A cycle start while one is still in progress is flagged and dropped.
        if (start && (state_reg != S_IDLE)) begin
            perr_next = 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_next     = is_io ? {8'd0, addr[15:1], 1'b0} : {addr[23:1], 1'b0};
                    wdata_next    = dout;
                    be_next       = {~n_ube, ~addr[0]};
                    we_next       = is_write;
                    io_next       = is_io;
                    rd_next       = returns_data & ~lane_err;
                    wait_cnt_next = wait_states;
                    if (cyc_type == C_INT_ACK) begin
                        resp_next = {8'hff, int_vector};
                    end
                    if (cyc_type == C_HALT_ACK) begin
                        halt_ack_next = 1'b1;
                    end
                    if ((cyc_type == C_INVALID) || lane_err) begin
                        perr_next = 1'b1;
                    end
                    // Cycles without a legal backend access go straight to wait counting.
                    state_next = (is_access && !lane_err) ? S_ACCESS : S_WAIT;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    if (rd_reg) begin
                        resp_next = mem_rdata;
                    end
                    state_next = S_WAIT;
                    // Ack coinciding with ce_1 still lets a zero-wait cycle finish now.
                    if (ce_1) begin
                        if (wait_cnt_reg == 4'd0) begin
                            n_ready_next = 1'b0;
                            if (rd_reg) begin
                                din_next = mem_rdata;
                            end
                            state_next = S_READY;
                        end else begin
                            wait_cnt_next = wait_cnt_reg - 4'd1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (ce_1) begin
                    if (wait_cnt_reg == 4'd0) begin
                        n_ready_next = 1'b0;
                        if (rd_reg) begin
                            din_next = resp_reg;
                        end
                        state_next = S_READY;
                    end else begin
                        wait_cnt_next = wait_cnt_reg - 4'd1;
                    end
                end
            end
            S_READY: begin
                if (ce_2) begin
                    n_ready_next = 1'b1;
                    state_next   = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign mem_req        = (state_reg == S_ACCESS);
    assign mem_we         = mem_req & we_reg;
    assign mem_io         = mem_req & io_reg;
    assign mem_be         = mem_req ? be_reg : 2'b00;
    assign mem_addr       = addr_reg;
    assign mem_wdata      = wdata_reg;
    assign din            = din_reg;
    assign n_ready        = n_ready_reg;
    assign halt_ack       = halt_ack_reg;
    assign protocol_error = perr_reg;

endmodule

// File: tb/tb_v33_bus_responder.sv
// Testbench for v33_bus_responder: table of directed bus cycles plus a
// hand-written reset-during-access sequence.
`timescale 1ns/1ps

module tb_v33_bus_responder;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        ce_1 = 1'b0;
    logic        ce_2 = 1'b0;
    logic        n_bcyst = 1'b1;
    logic        r_w = 1'b1;
    logic        m_io = 1'b1;
    logic        busst1 = 1'b1;
    logic        busst0 = 1'b1;
    logic        n_ube = 1'b1;
    logic [23:0] addr = 24'd0;
    logic [15:0] dout = 16'd0;
    logic [15:0] din;
    logic        n_ready;
    logic [3:0]  wait_states = 4'd0;
    logic [7:0]  int_vector = 8'd0;
    logic        mem_req;
    logic        mem_we;
    logic        mem_io;
    logic [23:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_ack = 1'b0;
    logic        halt_ack;
    logic        protocol_error;

    int          total = 0;
    int          bad = 0;
    logic [1:0]  phase = 2'd3;
    logic [15:0] model_din = 16'hffff;
    logic        model_perr = 1'b0;

    always #5 clk = ~clk;

    v33_bus_responder dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .ce_1           (ce_1),
        .ce_2           (ce_2),
        .n_bcyst        (n_bcyst),
        .r_w            (r_w),
        .m_io           (m_io),
        .busst1         (busst1),
        .busst0         (busst0),
        .n_ube          (n_ube),
        .addr           (addr),
        .dout           (dout),
        .din            (din),
        .n_ready        (n_ready),
        .wait_states    (wait_states),
        .int_vector     (int_vector),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_io         (mem_io),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .halt_ack       (halt_ack),
        .protocol_error (protocol_error)
    );

    typedef struct {
        logic        pre_reset;
        logic        poke;      // start strobe during WAIT
        logic [3:0]  stat;      // {m_io, r_w, busst1, busst0}
        logic        n_ube;
        logic [23:0] addr;
        logic [15:0] dout;
        logic [3:0]  ws;
        logic [7:0]  ivec;
        logic [15:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic        exp_io;
        logic [1:0]  exp_be;
        logic [23:0] exp_addr;
        logic        exp_halt;
        int          exp_ce1;
        logic        upd_din;
        logic [15:0] exp_din;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Move to the next negedge and set the phase enables for the coming posedge.
    task automatic advance();
        @(negedge clk);
        phase = phase + 2'd1;
        ce_1  = (phase == 2'd0);
        ce_2  = (phase == 2'd2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_n_ready"}, {31'd0, n_ready}, 32'd1);
        check({tag, "_din"}, {16'd0, din}, 32'h0000ffff);
        check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_io"}, {31'd0, mem_io}, 32'd0);
        check({tag, "_mem_be"}, {30'd0, mem_be}, 32'd0);
        check({tag, "_halt_ack"}, {31'd0, halt_ack}, 32'd0);
        check({tag, "_perr"}, {31'd0, protocol_error}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        check_reset_values("reset");
        advance();
        advance();
        n_reset    = 1'b1;
        model_din  = 16'hffff;
        model_perr = 1'b0;
    endtask

    task automatic run_cycle(input int idx, input vec_t v);
        int   n;
        logic seen;
        logic req_seen;
        logic poked;
        logic was_ce1;
        logic was_ce2;
        if (v.pre_reset) do_reset();
        while (phase != 2'd1) advance();
        // next advance leaves ce_2 set for the following posedge
        advance();
        {m_io, r_w, busst1, busst0} = v.stat;
        n_ube       = v.n_ube;
        addr        = v.addr;
        dout        = v.dout;
        wait_states = v.ws;
        int_vector  = v.ivec;
        n_bcyst     = 1'b0;
        advance();                       // latch edge
        n_bcyst     = 1'b1;
        int_vector  = 8'h00;
        wait_states = 4'd9;
        dout        = 16'h0bad;
        check($sformatf("v%0d_halt_ack", idx), {31'd0, halt_ack}, {31'd0, v.exp_halt});
        check($sformatf("v%0d_mem_req", idx), {31'd0, mem_req}, {31'd0, v.exp_req});
        if (v.exp_req) begin
            check($sformatf("v%0d_mem_we", idx), {31'd0, mem_we}, {31'd0, v.exp_we});
            check($sformatf("v%0d_mem_io", idx), {31'd0, mem_io}, {31'd0, v.exp_io});
            check($sformatf("v%0d_mem_be", idx), {30'd0, mem_be}, {30'd0, v.exp_be});
            check($sformatf("v%0d_mem_addr", idx), {8'd0, mem_addr}, {8'd0, v.exp_addr});
            check($sformatf("v%0d_mem_wdata", idx), {16'd0, mem_wdata}, {16'd0, v.dout});
        end
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
        advance();                       // ack edge
        mem_ack   = 1'b0;
        mem_rdata = 16'h6666;
        check($sformatf("v%0d_halt_pulse_end", idx), {31'd0, halt_ack}, 32'd0);
        check($sformatf("v%0d_req_dropped", idx), {31'd0, mem_req}, 32'd0);
        if (v.upd_din) model_din = v.exp_din;
        if (v.exp_err) model_perr = 1'b1;
        n = 0;
        seen = 1'b0;
        req_seen = 1'b0;
        poked = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (v.poke && !poked && ce_2) begin
                n_bcyst = 1'b0;
                poked   = 1'b1;
            end
            was_ce1 = ce_1;
            advance();
            n_bcyst = 1'b1;
            if (mem_req) req_seen = 1'b1;
            if (was_ce1) n++;
            if (n_ready == 1'b0) seen = 1'b1;
        end
        check($sformatf("v%0d_nready_seen", idx), {31'd0, seen}, 32'd1);
        check($sformatf("v%0d_ce1_count", idx), n, v.exp_ce1);
        check($sformatf("v%0d_din", idx), {16'd0, din}, {16'd0, model_din});
        if (!v.exp_req) check($sformatf("v%0d_no_backend", idx), {31'd0, req_seen}, 32'd0);
        check($sformatf("v%0d_perr", idx), {31'd0, protocol_error}, {31'd0, model_perr});
        for (int k = 0; k < 8; k++) begin
            was_ce2 = ce_2;
            advance();
            if (was_ce2) break;
        end
        check($sformatf("v%0d_nready_release", idx), {31'd0, n_ready}, 32'd1);
        check($sformatf("v%0d_din_hold", idx), {16'd0, din}, {16'd0, model_din});
        $display("vec %0d: stat=%b addr=%h ce1_count=%0d din=%h perr=%b",
                 idx, v.stat, v.addr, n, din, protocol_error);
    endtask

    initial begin
        logic low_seen;
        logic req_seen;

        //            pre poke stat     ube addr        dout      ws     ivec   rdata     req we io be     exp_addr    hlt ce1 upd din       err
        vecs[0] = '{1'b0, 1'b0, 4'b1100, 1'b0, 24'h001234, 16'h1111, 4'd0,  8'h00, 16'hbeef, 1'b1, 1'b0, 1'b0, 2'b11, 24'h001234, 1'b0, 1,  1'b1, 16'hbeef, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 4'b1001, 1'b0, 24'h000101, 16'h5a00, 4'd3,  8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b10, 24'h000100, 1'b0, 4,  1'b0, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 4'b0100, 1'b0, 24'h000000, 16'h0000, 4'd1,  8'h21, 16'h9999, 1'b0, 1'b0, 1'b0, 2'b00, 24'h000000, 1'b0, 2,  1'b1, 16'hff21, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 4'b0011, 1'b0, 24'h000000, 16'h0000, 4'd0,  8'h00, 16'h8888, 1'b0, 1'b0, 1'b0, 2'b00, 24'h000000, 1'b1, 1,  1'b0, 16'h0000, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 4'b0101, 1'b0, 24'hab5678, 16'h2222, 4'd2,  8'h00, 16'h1357, 1'b1, 1'b0, 1'b1, 2'b11, 24'h005678, 1'b0, 3,  1'b1, 16'h1357, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 4'b0001, 1'b0, 24'h00ff03, 16'hc3c3, 4'd0,  8'h00, 16'h0000, 1'b1, 1'b1, 1'b1, 2'b10, 24'h00ff02, 1'b0, 1,  1'b0, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 4'b1101, 1'b1, 24'h800010, 16'h0000, 4'd15, 8'h00, 16'ha55a, 1'b1, 1'b0, 1'b0, 2'b01, 24'h800010, 1'b0, 16, 1'b1, 16'ha55a, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 4'b1100, 1'b1, 24'h000201, 16'h0000, 4'd0,  8'h00, 16'h7777, 1'b0, 1'b0, 1'b0, 2'b00, 24'h000000, 1'b0, 1,  1'b0, 16'h0000, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 4'b1010, 1'b0, 24'h000400, 16'h0000, 4'd0,  8'h00, 16'h4444, 1'b0, 1'b0, 1'b0, 2'b00, 24'h000000, 1'b0, 1,  1'b0, 16'h0000, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 4'b0100, 1'b0, 24'h000000, 16'h0000, 4'd4,  8'h7e, 16'h3333, 1'b0, 1'b0, 1'b0, 2'b00, 24'h000000, 1'b0, 5,  1'b1, 16'hff7e, 1'b1};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            run_cycle(i, vecs[i]);
        end

        // Reset while the backend access is outstanding, then a late ack.
        while (phase != 2'd1) advance();
        advance();
        {m_io, r_w, busst1, busst0} = 4'b1100;
        n_ube       = 1'b0;
        addr        = 24'h000888;
        wait_states = 4'd0;
        n_bcyst     = 1'b0;
        advance();
        n_bcyst     = 1'b1;
        check("abort_req_active", {31'd0, mem_req}, 32'd1);
        #2;
        n_reset = 1'b0;
        #1;
        check_reset_values("abort");
        advance();
        n_reset   = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hdead;
        advance();
        mem_ack   = 1'b0;
        low_seen  = 1'b0;
        req_seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            advance();
            if (!n_ready) low_seen = 1'b1;
            if (mem_req) req_seen = 1'b1;
        end
        check("abort_nready_stays_high", {31'd0, low_seen}, 32'd0);
        check("abort_no_req", {31'd0, req_seen}, 32'd0);
        check("abort_din", {16'd0, din}, 32'h0000ffff);
        check("abort_perr", {31'd0, protocol_error}, 32'd0);
        $display("abort: n_ready_low_seen=%b din=%h", low_seen, din);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
